// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel sequencer: FSM states, command codes,
// switch bit positions inside sw_n, and the press-priority encoder.
package panel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT_ACK,
    ST_HOLD
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_ALOAD,
    CMD_EXTD,
    CMD_DEP,
    CMD_EXAM,
    CMD_CONT
  } cmd_t;

  // Bit positions in sw_n = {clearn, addr_loadn, extd_addrn, depn, examn, contn, haltn}
  localparam int unsigned SW_HALT  = 0;
  localparam int unsigned SW_CONT  = 1;
  localparam int unsigned SW_EXAM  = 2;
  localparam int unsigned SW_DEP   = 3;
  localparam int unsigned SW_EXTD  = 4;
  localparam int unsigned SW_ALOAD = 5;
  localparam int unsigned SW_CLEAR = 6;
  localparam int unsigned NUM_SW   = 7;

  // Exactly one command wins when several presses debounce in the same cycle.
  function automatic cmd_t pick_cmd(input logic [SW_CLEAR:SW_CONT] press);
    if (press[SW_CLEAR])      return CMD_CLEAR;
    else if (press[SW_ALOAD]) return CMD_ALOAD;
    else if (press[SW_EXTD])  return CMD_EXTD;
    else if (press[SW_DEP])   return CMD_DEP;
    else if (press[SW_EXAM])  return CMD_EXAM;
    else if (press[SW_CONT])  return CMD_CONT;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/panel_if.sv
// Memory port between the panel sequencer (master) and the memory system (slave).
interface panel_if;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_ack;
  logic [11:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/panel_debounce.sv
// One panel switch: 2-flop synchronizer followed by a stability counter.
// level is active-high (1 = pressed) and resets to released.
module panel_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic sw_n,
  output logic level
);

  logic [1:0]  sync;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], ~sw_n};
      // Any cycle agreeing with the current level restarts the count.
      if (sync[1] != level) begin
        if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/panel_sequencer.sv
// Front-panel command sequencer: debounces the panel switches and turns presses
// into CPU pulses, address loads and memory accesses. Option: PANEL_AUTOINC_EN.
module panel_sequencer
  import panel_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [6:0]     sw_n,
  input  logic [11:0]    sr,
  input  logic           cpu_halted,
  panel_if.master        mem,
  output logic [11:0]    exam_data,
  output logic           cpu_clear,
  output logic           cpu_cont,
  output logic           halt_req
);

  logic [NUM_SW-1:0]        sw_lvl;
  logic [SW_CLEAR:SW_CONT]  lvl_q;
  logic [SW_CLEAR:SW_CONT]  press;
  state_t                   state, state_nx;
  cmd_t                     cmd_q;
  logic [11:0]              sr_q;
  logic [14:0]              pa;
  logic                     accept;
  logic                     ack_done;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .resetn(resetn),
      .sw_n  (sw_n[i]),
      .level (sw_lvl[i])
    );
  end

  assign press    = sw_lvl[SW_CLEAR:SW_CONT] & ~lvl_q;
  assign halt_req = sw_lvl[SW_HALT];

  assign mem.mem_addr  = pa;
  assign mem.mem_wdata = sr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      lvl_q <= '0;
    end else begin
      state <= state_nx;
      lvl_q <= sw_lvl[SW_CLEAR:SW_CONT];
    end
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    ack_done    = 1'b0;
    cpu_clear   = 1'b0;
    cpu_cont    = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Presses seen while the CPU runs are dropped, never queued.
        if (cpu_halted && (|press)) begin
          accept   = 1'b1;
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cpu_clear = (cmd_q == CMD_CLEAR);
        cpu_cont  = (cmd_q == CMD_CONT);
        if (cmd_q == CMD_DEP || cmd_q == CMD_EXAM) begin
          mem.mem_req = 1'b1;
          mem.mem_we  = (cmd_q == CMD_DEP);
          state_nx    = ST_WAIT_ACK;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      ST_WAIT_ACK: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (cmd_q == CMD_DEP);
        if (mem.mem_ack) begin
          ack_done = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!(|sw_lvl[SW_CLEAR:SW_CONT])) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q     <= CMD_NONE;
      sr_q      <= '0;
      pa        <= '0;
      exam_data <= '0;
    end else begin
      if (accept) begin
        cmd_q <= pick_cmd(press);
        sr_q  <= sr;
      end
      if (state == ST_EXEC) begin
        if (cmd_q == CMD_ALOAD) pa[11:0]  <= sr_q;
        if (cmd_q == CMD_EXTD)  pa[14:12] <= sr_q[2:0];
      end
      if (ack_done) begin
        if (cmd_q == CMD_EXAM) exam_data <= mem.mem_rdata;
`ifdef PANEL_AUTOINC_EN
        pa[11:0] <= pa[11:0] + 12'd1;
`endif
      end
    end
  end

endmodule
